// File: rtl/pu_riscv_verilog_pkg.sv
// Shared core types: data-memory port owner encoding and arbiter depth.
package pu_riscv_verilog_pkg;

   typedef enum logic {
      OWNER_LSU = 1'b0,
      OWNER_PTW = 1'b1
   } dmem_owner_t;

   localparam int DMEM_ARB_OUTSTANDING = 4;

endpackage

// File: rtl/pu_riscv_owner_fifo.sv
// 1-bit synchronous FIFO remembering which requester owns each outstanding access.
module pu_riscv_owner_fifo
   import pu_riscv_verilog_pkg::*;
#(
   parameter int DEPTH = DMEM_ARB_OUTSTANDING
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic head,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/pu_riscv_dmem_arbiter.sv
// Round-robin share of the data-memory port between LSU and PTW, with
// in-order response routing through an owner FIFO.
module pu_riscv_dmem_arbiter
   import pu_riscv_verilog_pkg::*;
#(
   parameter int XLEN            = 64,
   parameter int MAX_OUTSTANDING = DMEM_ARB_OUTSTANDING
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            lsu_req_i,
   input  logic            lsu_we_i,
   input  logic [2:0]      lsu_size_i,
   input  logic [XLEN-1:0] lsu_adr_i,
   input  logic [XLEN-1:0] lsu_d_i,
   output logic            lsu_gnt_o,
   output logic            lsu_ack_o,
   output logic            lsu_err_o,
   output logic [XLEN-1:0] lsu_q_o,
   input  logic            ptw_req_i,
   input  logic            ptw_we_i,
   input  logic [2:0]      ptw_size_i,
   input  logic [XLEN-1:0] ptw_adr_i,
   input  logic [XLEN-1:0] ptw_d_i,
   output logic            ptw_gnt_o,
   output logic            ptw_ack_o,
   output logic            ptw_err_o,
   output logic [XLEN-1:0] ptw_q_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [2:0]      mem_size_o,
   output logic [XLEN-1:0] mem_adr_o,
   output logic [XLEN-1:0] mem_d_o,
   input  logic            mem_stall_i,
   input  logic            mem_ack_i,
   input  logic            mem_err_i,
   input  logic [XLEN-1:0] mem_q_i,
   output logic            spurious_o
);

   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_head;
   logic        prio_ptw;
   logic        hold_vld;
   dmem_owner_t hold_owner;
   dmem_owner_t winner;
   logic        winner_req;
   logic        accept;
   logic        resp_any;
   logic        resp;
   logic        resp_ack;

   // A stalled winner stays selected until accepted, so mem_* cannot change under it
   always_comb begin
      winner = OWNER_LSU;
      if (hold_vld)
         winner = hold_owner;
      else if (lsu_req_i && ptw_req_i)
         winner = prio_ptw ? OWNER_PTW : OWNER_LSU;
      else if (ptw_req_i)
         winner = OWNER_PTW;
   end

   assign winner_req = (winner == OWNER_PTW) ? ptw_req_i : lsu_req_i;
   assign mem_req_o  = rst_ni & ~fifo_full & winner_req;
   assign accept     = mem_req_o & ~mem_stall_i;
   assign lsu_gnt_o  = accept & (winner == OWNER_LSU);
   assign ptw_gnt_o  = accept & (winner == OWNER_PTW);

   always_comb begin
      mem_we_o   = 1'b0;
      mem_size_o = '0;
      mem_adr_o  = '0;
      mem_d_o    = '0;
      if (mem_req_o) begin
         if (winner == OWNER_PTW) begin
            mem_we_o   = ptw_we_i;
            mem_size_o = ptw_size_i;
            mem_adr_o  = ptw_adr_i;
            mem_d_o    = ptw_d_i;
         end else begin
            mem_we_o   = lsu_we_i;
            mem_size_o = lsu_size_i;
            mem_adr_o  = lsu_adr_i;
            mem_d_o    = lsu_d_i;
         end
      end
   end

   // An error wins over a simultaneous ack; either one retires the head entry
   assign resp_any  = mem_ack_i | mem_err_i;
   assign resp      = resp_any & ~fifo_empty;
   assign resp_ack  = mem_ack_i & ~mem_err_i;
   assign lsu_ack_o = resp & ~fifo_head & resp_ack;
   assign lsu_err_o = resp & ~fifo_head & mem_err_i;
   assign ptw_ack_o = resp & fifo_head & resp_ack;
   assign ptw_err_o = resp & fifo_head & mem_err_i;
   assign lsu_q_o   = lsu_ack_o ? mem_q_i : '0;
   assign ptw_q_o   = ptw_ack_o ? mem_q_i : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_ptw   <= 1'b0;
         hold_vld   <= 1'b0;
         hold_owner <= OWNER_LSU;
         spurious_o <= 1'b0;
      end else begin
         if (accept) prio_ptw <= (winner == OWNER_LSU);
         hold_vld   <= mem_req_o & mem_stall_i;
         hold_owner <= winner;
         if (resp_any && fifo_empty) spurious_o <= 1'b1;
      end
   end

   pu_riscv_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (accept),
      .din    (winner),
      .pop    (resp),
      .head   (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

endmodule

// File: tb/tb_pu_riscv_dmem_arbiter.sv
// Bench for pu_riscv_dmem_arbiter: directed table, corner sequences, random vs queue model.
module tb_pu_riscv_dmem_arbiter;

   localparam int XLEN = 64;
   localparam int MO   = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            lsu_req = 0, lsu_we = 0, ptw_req = 0, ptw_we = 0;
   logic [2:0]      lsu_size = 0, ptw_size = 0;
   logic [XLEN-1:0] lsu_adr = 0, lsu_d = 0, ptw_adr = 0, ptw_d = 0;
   logic            lsu_gnt, lsu_ack, lsu_err, ptw_gnt, ptw_ack, ptw_err;
   logic [XLEN-1:0] lsu_q, ptw_q;
   logic            mem_req, mem_we;
   logic [2:0]      mem_size;
   logic [XLEN-1:0] mem_adr, mem_d;
   logic            mem_stall = 0, mem_ack = 0, mem_err = 0;
   logic [XLEN-1:0] mem_q = 0;
   logic            spurious;

   always #5 clk = ~clk;

   pu_riscv_dmem_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
      .lsu_adr_i(lsu_adr), .lsu_d_i(lsu_d),
      .lsu_gnt_o(lsu_gnt), .lsu_ack_o(lsu_ack), .lsu_err_o(lsu_err), .lsu_q_o(lsu_q),
      .ptw_req_i(ptw_req), .ptw_we_i(ptw_we), .ptw_size_i(ptw_size),
      .ptw_adr_i(ptw_adr), .ptw_d_i(ptw_d),
      .ptw_gnt_o(ptw_gnt), .ptw_ack_o(ptw_ack), .ptw_err_o(ptw_err), .ptw_q_o(ptw_q),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_size_o(mem_size),
      .mem_adr_o(mem_adr), .mem_d_o(mem_d),
      .mem_stall_i(mem_stall), .mem_ack_i(mem_ack), .mem_err_i(mem_err), .mem_q_i(mem_q),
      .spurious_o(spurious)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic drive(input logic lr, input logic pr, input logic st,
                        input logic ak, input logic er, input logic [63:0] q);
      lsu_req = lr; ptw_req = pr; mem_stall = st; mem_ack = ak; mem_err = er; mem_q = q;
   endtask

   typedef struct {
      logic lr, pr, st, ak, er;
      logic [63:0] q;
      logic gl, gp, req;
      logic [63:0] adr;
      logic al, el, ap, ep;
      logic [63:0] ql, qp;
   } vec_t;

   vec_t tbl[7];

   // reference model state
   int   own_q[$];
   bit   m_last_ptw, m_held_v, m_held, m_spur;

   task automatic model_reset();
      own_q.delete();
      m_last_ptw = 1'b1;
      m_held_v = 1'b0;
      m_held = 1'b0;
      m_spur = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{1,1,0,0,0,64'h0,               1,0,1,64'h1000, 0,0,0,0, 64'h0,    64'h0};
      tbl[1] = '{1,1,0,0,0,64'h0,               0,1,1,64'h2000, 0,0,0,0, 64'h0,    64'h0};
      tbl[2] = '{1,1,0,1,0,64'h1111,            1,0,1,64'h1000, 1,0,0,0, 64'h1111, 64'h0};
      tbl[3] = '{1,1,0,1,0,64'hDEAD_BEEF,       0,1,1,64'h2000, 0,0,1,0, 64'h0,    64'hDEAD_BEEF};
      tbl[4] = '{1,1,0,1,0,64'h2222,            1,0,1,64'h1000, 1,0,0,0, 64'h2222, 64'h0};
      tbl[5] = '{0,0,0,1,0,64'h3333,            0,0,0,64'h0,    0,0,1,0, 64'h0,    64'h3333};
      tbl[6] = '{0,0,0,1,0,64'h4444,            0,0,0,64'h0,    1,0,0,0, 64'h4444, 64'h0};

      // reset hold with both requesting
      lsu_adr = 64'h1000; ptw_adr = 64'h2000;
      drive(1, 1, 0, 0, 0, 0);
      tick(); settle();
      chk1("rst_mem_req", mem_req, 0);
      chk1("rst_lsu_gnt", lsu_gnt, 0);
      chk1("rst_ptw_gnt", ptw_gnt, 0);
      chk64("rst_mem_adr", mem_adr, 0);
      chk1("rst_spurious", spurious, 0);
      tick();
      rst_n = 1'b1;

      // alternating grants with in-order routing; row 0 is the first cycle after release
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].lr, tbl[i].pr, tbl[i].st, tbl[i].ak, tbl[i].er, tbl[i].q);
         settle();
         chk1($sformatf("tbl%0d_lsu_gnt", i), lsu_gnt, tbl[i].gl);
         chk1($sformatf("tbl%0d_ptw_gnt", i), ptw_gnt, tbl[i].gp);
         chk1($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].req);
         chk64($sformatf("tbl%0d_mem_adr", i), mem_adr, tbl[i].adr);
         chk1($sformatf("tbl%0d_lsu_ack", i), lsu_ack, tbl[i].al);
         chk1($sformatf("tbl%0d_lsu_err", i), lsu_err, tbl[i].el);
         chk1($sformatf("tbl%0d_ptw_ack", i), ptw_ack, tbl[i].ap);
         chk1($sformatf("tbl%0d_ptw_err", i), ptw_err, tbl[i].ep);
         chk64($sformatf("tbl%0d_lsu_q", i), lsu_q, tbl[i].ql);
         chk64($sformatf("tbl%0d_ptw_q", i), ptw_q, tbl[i].qp);
         tick();
      end

      // fill to MAX_OUTSTANDING, then pop while full
      for (int i = 0; i < MO; i++) begin
         lsu_adr = 64'h100 + 64'(i);
         drive(1, 0, 0, 0, 0, 0); settle();
         chk1($sformatf("fill%0d_gnt", i), lsu_gnt, 1);
         tick();
      end
      drive(1, 0, 0, 0, 0, 0); settle();
      chk1("full_gnt", lsu_gnt, 0);
      chk1("full_mem_req", mem_req, 0);
      tick();
      drive(1, 0, 0, 1, 0, 64'h55); settle();
      chk1("full_pop_gnt", lsu_gnt, 0);
      chk1("full_pop_ack", lsu_ack, 1);
      tick();
      drive(1, 0, 0, 0, 0, 0); settle();
      chk1("after_pop_gnt", lsu_gnt, 1);
      tick();
      for (int i = 0; i < MO; i++) begin
         drive(0, 0, 0, 1, 0, 64'(i)); settle();
         chk1($sformatf("drain%0d_ack", i), lsu_ack, 1);
         tick();
      end

      // one PTW access so the LSU holds round-robin priority going into the stall
      ptw_adr = 64'h2040; lsu_adr = 64'h1040;
      drive(0, 1, 0, 0, 0, 0); settle();
      chk1("ptw_single_gnt", ptw_gnt, 1);
      tick();
      drive(0, 0, 0, 1, 0, 64'h7); settle();
      chk1("ptw_single_ack", ptw_ack, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(i > 0, 1, 1, 0, 0, 0); settle();
         chk1($sformatf("stall%0d_req", i), mem_req, 1);
         chk64($sformatf("stall%0d_adr", i), mem_adr, 64'h2040);
         chk1($sformatf("stall%0d_lsu_gnt", i), lsu_gnt, 0);
         chk1($sformatf("stall%0d_ptw_gnt", i), ptw_gnt, 0);
         tick();
      end
      drive(1, 1, 0, 0, 0, 0); settle();
      chk1("unstall_ptw_gnt", ptw_gnt, 1);
      chk1("unstall_lsu_gnt", lsu_gnt, 0);
      chk64("unstall_adr", mem_adr, 64'h2040);
      tick();
      drive(1, 0, 0, 0, 0, 0); settle();
      chk1("post_stall_lsu_gnt", lsu_gnt, 1);
      chk64("post_stall_adr", mem_adr, 64'h1040);
      tick();
      drive(0, 0, 0, 1, 0, 64'hA); settle();
      chk1("stall_resp_ptw", ptw_ack, 1);
      tick();
      drive(0, 0, 0, 1, 0, 64'hB); settle();
      chk1("stall_resp_lsu", lsu_ack, 1);
      tick();

      // error on the second of two LSU accesses, then a response with nothing outstanding
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 0, 0, 0); settle();
         chk1($sformatf("err_issue%0d", i), lsu_gnt, 1);
         tick();
      end
      drive(0, 0, 0, 1, 0, 64'hC); settle();
      chk1("err_seq_ack", lsu_ack, 1);
      chk1("err_seq_ack_err", lsu_err, 0);
      tick();
      drive(0, 0, 0, 0, 1, 64'hD); settle();
      chk1("err_seq_err", lsu_err, 1);
      chk1("err_seq_err_ack", lsu_ack, 0);
      chk64("err_seq_err_q", lsu_q, 0);
      chk1("err_seq_spur_before", spurious, 0);
      tick();
      drive(0, 0, 0, 1, 0, 64'hE); settle();
      chk1("spur_lsu_ack", lsu_ack, 0);
      chk1("spur_ptw_ack", ptw_ack, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0); settle();
      chk1("spur_set", spurious, 1);

      // reset with outstanding accesses, then a late ack
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 0); tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0; settle();
      chk1("midrst_spur_clr", spurious, 0);
      chk1("midrst_mem_req", mem_req, 0);
      tick();
      rst_n = 1'b1;
      drive(0, 0, 0, 1, 0, 64'hF); settle();
      chk1("late_lsu_ack", lsu_ack, 0);
      chk1("late_ptw_ack", ptw_ack, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0); settle();
      chk1("late_spur", spurious, 1);

      // randomized traffic against the queue model
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 2000; c++) begin
         bit full, mreq, who, acc, resp, has, o;
         bit e_la, e_le, e_pa, e_pe;
         if (!lsu_req && $urandom_range(0, 2) == 0) begin
            lsu_req = 1; lsu_we = 1'($urandom); lsu_size = 3'($urandom);
            lsu_adr = {$urandom, $urandom}; lsu_d = {$urandom, $urandom};
         end
         if (!ptw_req && $urandom_range(0, 3) == 0) begin
            ptw_req = 1; ptw_we = 1'($urandom); ptw_size = 3'($urandom);
            ptw_adr = {$urandom, $urandom}; ptw_d = {$urandom, $urandom};
         end
         mem_stall = ($urandom_range(0, 3) == 0);
         mem_ack   = ($urandom_range(0, 2) == 0);
         mem_err   = ($urandom_range(0, 9) == 0);
         mem_q     = {$urandom, $urandom};

         full = (own_q.size() == MO);
         who = 0; mreq = 0;
         if (!full) begin
            if (m_held_v && (m_held ? ptw_req : lsu_req)) begin
               who = m_held; mreq = 1;
            end else if (lsu_req && ptw_req) begin
               who = !m_last_ptw; mreq = 1;
            end else if (lsu_req || ptw_req) begin
               who = ptw_req; mreq = 1;
            end
         end
         acc  = mreq && !mem_stall;
         resp = mem_ack || mem_err;
         has  = resp && own_q.size() > 0;
         o    = has ? bit'(own_q[0]) : 1'b0;
         e_la = has && !o && !mem_err;
         e_le = has && !o && mem_err;
         e_pa = has && o && !mem_err;
         e_pe = has && o && mem_err;

         settle();
         chk1("rnd_lsu_gnt", lsu_gnt, acc && !who);
         chk1("rnd_ptw_gnt", ptw_gnt, acc && who);
         chk1("rnd_mem_req", mem_req, mreq);
         chk64("rnd_mem_adr", mem_adr, !mreq ? 64'h0 : (who ? ptw_adr : lsu_adr));
         chk64("rnd_mem_d", mem_d, !mreq ? 64'h0 : (who ? ptw_d : lsu_d));
         chk64("rnd_mem_we_size", {60'h0, mem_we, mem_size},
               !mreq ? 64'h0 : (who ? {60'h0, ptw_we, ptw_size} : {60'h0, lsu_we, lsu_size}));
         chk1("rnd_lsu_ack", lsu_ack, e_la);
         chk1("rnd_lsu_err", lsu_err, e_le);
         chk1("rnd_ptw_ack", ptw_ack, e_pa);
         chk1("rnd_ptw_err", ptw_err, e_pe);
         chk64("rnd_lsu_q", lsu_q, e_la ? mem_q : 64'h0);
         chk64("rnd_ptw_q", ptw_q, e_pa ? mem_q : 64'h0);
         chk1("rnd_spurious", spurious, m_spur);
         tick();

         if (resp && own_q.size() == 0) m_spur = 1;
         if (has) void'(own_q.pop_front());
         if (acc) begin
            own_q.push_back(int'(who));
            m_last_ptw = who;
            if (who) ptw_req = 0;
            else lsu_req = 0;
         end
         m_held_v = mreq && mem_stall;
         m_held   = who;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
